// File: rtl/leg_pkg.sv
// Shared constants and types for the LEG execute stage: opcodes, register
// indices and the RUN/FLUSH state encoding.
package leg_pkg;

  localparam int XLEN = 8;

  localparam logic [2:0] IO_REG = 3'd7;

  localparam logic [5:0] OP_ADD = 6'd0;
  localparam logic [5:0] OP_SUB = 6'd1;
  localparam logic [5:0] OP_AND = 6'd2;
  localparam logic [5:0] OP_OR  = 6'd3;
  localparam logic [5:0] OP_NOT = 6'd4;
  localparam logic [5:0] OP_XOR = 6'd5;

  localparam logic [5:0] OP_EQ  = 6'd32;
  localparam logic [5:0] OP_NE  = 6'd33;
  localparam logic [5:0] OP_LT  = 6'd34;
  localparam logic [5:0] OP_LE  = 6'd35;
  localparam logic [5:0] OP_GT  = 6'd36;
  localparam logic [5:0] OP_GE  = 6'd37;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  function automatic logic is_alu_op(input logic [5:0] op);
    return op <= OP_XOR;
  endfunction

endpackage

// File: rtl/leg_alu.sv
// Combinational ALU + unsigned comparator. Produces a register-write result
// for ALU ops and a jump-taken flag for compare ops; anything else is a NOP.
module leg_alu
  import leg_pkg::*;
(
  input  logic [5:0]      op,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  output logic [XLEN-1:0] result,
  output logic            wr_en,
  output logic            jump
);

  always_comb begin
    result = '0;
    wr_en  = is_alu_op(op);
    jump   = 1'b0;
    case (op)
      OP_ADD:  result = opa + opb;
      OP_SUB:  result = opa - opb;
      OP_AND:  result = opa & opb;
      OP_OR:   result = opa | opb;
      OP_NOT:  result = ~opa;
      OP_XOR:  result = opa ^ opb;
      OP_EQ:   jump = (opa == opb);
      OP_NE:   jump = (opa != opb);
      OP_LT:   jump = (opa <  opb);
      OP_LE:   jump = (opa <= opb);
      OP_GT:   jump = (opa >  opb);
      OP_GE:   jump = (opa >= opb);
      default: ;
    endcase
  end

endmodule

// File: rtl/leg_exec.sv
// LEG execute stage: operand fetch from R0-R6/io_in, ALU/compare via leg_alu,
// register/io writeback, and a RUN/FLUSH FSM that drops fetched instructions
// for FLUSH_CYCLES cycles after a taken jump.
module leg_exec
  import leg_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  input  logic [7:0] dir,
  input  logic [7:0] data_a,
  input  logic [7:0] data_b,
  input  logic [7:0] address,
  input  logic [7:0] io_in,
  output logic       skip,
  output logic [7:0] skip_data,
  output logic [7:0] io_out,
  output logic       io_out_valid
);

  localparam bit HAS_FLUSH = (FLUSH_CYCLES > 0);
  localparam int CNT_W     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HAS_FLUSH ? FLUSH_CYCLES - 1 : 0);

  // Slot 7 is never written: index 7 always decodes to the I/O port.
  logic [XLEN-1:0] regs [0:7];

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;

  logic [XLEN-1:0] opa, opb, result;
  logic            alu_wr, alu_jump;
  logic            accept, take, wr_io, wr_reg;
  logic [2:0]      dst;

  // Operand select: immediate, register, or io_in for index 7.
  always_comb begin
    if (dir[7])                     opa = data_a;
    else if (data_a[2:0] == IO_REG) opa = io_in;
    else                            opa = regs[data_a[2:0]];
    if (dir[6])                     opb = data_b;
    else if (data_b[2:0] == IO_REG) opb = io_in;
    else                            opb = regs[data_b[2:0]];
  end

  leg_alu u_alu (
    .op     (dir[5:0]),
    .opa    (opa),
    .opb    (opb),
    .result (result),
    .wr_en  (alu_wr),
    .jump   (alu_jump)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (take && HAS_FLUSH) state_d = ST_FLUSH;
      ST_FLUSH: if (cnt_q == '0)       state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // FSM: outputs (per-cycle control strobes)
  always_comb begin
    dst    = address[2:0];
    accept = (state_q == ST_RUN) && instr_valid;
    take   = accept && alu_jump;
    wr_io  = accept && alu_wr && (dst == IO_REG);
    wr_reg = accept && alu_wr && (dst != IO_REG);
  end

  // Counter is loaded on the accepting edge so the skip cycle is the first
  // flushed cycle.
  always_ff @(posedge clk) begin
    if (rst)                                  cnt_q <= '0;
    else if (take)                            cnt_q <= CNT_LOAD;
    else if (state_q == ST_FLUSH && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      skip         <= 1'b0;
      skip_data    <= '0;
      io_out       <= '0;
      io_out_valid <= 1'b0;
    end else begin
      skip         <= take;
      io_out_valid <= wr_io;
      if (take)   skip_data   <= address;
      if (wr_io)  io_out      <= result;
      if (wr_reg) regs[dst]   <= result;
    end
  end

endmodule
